// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory-port initiator.
// Also holds the bank-width helper used by the interface and the top module.
package mem_port_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} mpi_state_t;

  // Memory read latency in cycles, counted from o_en on the port to i_dout valid.
  localparam int RD_LAT = 1;

  function automatic int bank_w(input int num_bank);
    return (num_bank > 1) ? $clog2(num_bank) : 1;
  endfunction

endpackage

// File: rtl/mem_port_initiator_if.sv
// Command, write-data, read-data and memory-port signals of one initiator.
// master = the initiator itself, slave = the environment (requester + memory).
interface mem_port_initiator_if
  import mem_port_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_TOTAL = 10,
  parameter int NUM_BANK   = 4,
  parameter int MAX_BURST  = 16
);
  localparam int BANK_W = bank_w(NUM_BANK);
  localparam int LOC_W  = ADDR_TOTAL - BANK_W;
  localparam int LEN_W  = $clog2(MAX_BURST);

  // Handshake rule for cmd, wdata and rdata: a transfer happens on a rising
  // edge where valid and ready are both high; valid must not depend on ready.
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_we;
  logic [ADDR_TOTAL-1:0] i_cmd_addr;
  logic [LEN_W-1:0]      i_cmd_len;
  logic                  i_wdata_valid;
  logic                  o_wdata_ready;
  logic [WIDTH-1:0]      i_wdata;
  logic                  o_rdata_valid;
  logic                  i_rdata_ready;
  logic [WIDTH-1:0]      o_rdata;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_en;
  logic                  o_we;
  logic [WIDTH-1:0]      o_din;
  logic [LOC_W-1:0]      o_addr;
  logic [BANK_W-1:0]     o_bank_sel;
  logic [WIDTH-1:0]      i_dout;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_len,
    input  i_wdata_valid, i_wdata, i_rdata_ready, i_dout,
    output o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata,
    output o_busy, o_done, o_en, o_we, o_din, o_addr, o_bank_sel
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_len,
    output i_wdata_valid, i_wdata, i_rdata_ready, i_dout,
    input  o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata,
    input  o_busy, o_done, o_en, o_we, o_din, o_addr, o_bank_sel
  );

endinterface

// File: rtl/mpi_rd_fifo.sv
// Read-return queue: power-of-2 depth FIFO with occupancy count.
// Synchronous active-low reset flushes pointers and count; storage is not reset.
module mpi_rd_fifo #(
  parameter int WIDTH     = 8,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(RDQ_DEPTH):0] count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(RDQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [RDQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full queue is refused unless a pop frees a slot in the same cycle.
  assign do_push  = push && ((count != CNT_W'(RDQ_DEPTH)) || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_port_initiator.sv
// Burst requester for one memory port: commands in, write beats streamed out, reads returned
// through a credit-managed queue. Optional beat counters are built when MPI_STATS_EN is defined.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_TOTAL = 10,
  parameter int NUM_BANK   = 4,
  parameter int MAX_BURST  = 16,
  parameter int RDQ_DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  mem_port_initiator_if.master    bus,
  output mpi_state_t              o_dbg_state
`ifdef MPI_STATS_EN
  ,
  output logic [31:0]             o_wr_count,
  output logic [31:0]             o_rd_count
`endif
);
  localparam int BANK_W = bank_w(NUM_BANK);
  localparam int LOC_W  = ADDR_TOTAL - BANK_W;
  localparam int LEN_W  = $clog2(MAX_BURST);
  localparam int CNT_W  = $clog2(RDQ_DEPTH) + 1;

  mpi_state_t            state;
  logic [ADDR_TOTAL-1:0] ptr;
  logic [LEN_W-1:0]      beats;
  logic [1:0]            inflight;
  logic [1:0]            inflight_nxt;
  logic [RD_LAT-1:0]     rd_pipe;

  logic                  cmd_ready;
  logic                  wdata_ready;
  logic                  busy;
  logic                  done;
  logic                  en;
  logic                  we;
  logic [WIDTH-1:0]      din;
  logic [LOC_W-1:0]      addr;
  logic [BANK_W-1:0]     bank_sel;

  logic                  q_push;
  logic                  q_pop;
  logic                  q_empty;
  logic [WIDTH-1:0]      q_data;
  logic [CNT_W-1:0]      q_count;

  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  rd_fire;

  assign cmd_fire = cmd_ready && bus.i_cmd_valid;
  assign wr_fire  = (state == WRITE) && wdata_ready && bus.i_wdata_valid;
  // Credit: a read may be issued only if every outstanding read still has a queue slot.
  assign rd_fire  = (state == READ) && ((int'(inflight) + int'(q_count)) < RDQ_DEPTH);

  // rd_pipe tracks reads on the port; its last stage marks the cycle i_dout holds their data.
  assign q_push       = rd_pipe[RD_LAT-1];
  assign q_pop        = !q_empty && bus.i_rdata_ready;
  assign inflight_nxt = inflight + {1'b0, rd_fire} - {1'b0, q_push};

  mpi_rd_fifo #(
    .WIDTH     (WIDTH),
    .RDQ_DEPTH (RDQ_DEPTH)
  ) u_rd_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (q_push),
    .push_data (bus.i_dout),
    .pop       (q_pop),
    .pop_data  (q_data),
    .count     (q_count),
    .empty     (q_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      beats       <= '0;
      inflight    <= '0;
      rd_pipe     <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      en          <= 1'b0;
      we          <= 1'b0;
      din         <= '0;
      addr        <= '0;
      bank_sel    <= '0;
    end else begin
      en       <= 1'b0;
      we       <= 1'b0;
      done     <= 1'b0;
      inflight <= inflight_nxt;
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(en & ~we);
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            ptr       <= bus.i_cmd_addr;
            beats     <= bus.i_cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (bus.i_cmd_we) begin
              state       <= WRITE;
              wdata_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            en       <= 1'b1;
            we       <= 1'b1;
            din      <= bus.i_wdata;
            addr     <= ptr[LOC_W-1:0];
            bank_sel <= ptr[ADDR_TOTAL-1 -: BANK_W];
            ptr      <= ptr + ADDR_TOTAL'(1);
            if (beats == '0) begin
              done        <= 1'b1;
              state       <= IDLE;
              wdata_ready <= 1'b0;
              busy        <= 1'b0;
              cmd_ready   <= 1'b1;
            end else begin
              beats <= beats - LEN_W'(1);
            end
          end
        end
        READ: begin
          if (rd_fire) begin
            en       <= 1'b1;
            addr     <= ptr[LOC_W-1:0];
            bank_sel <= ptr[ADDR_TOTAL-1 -: BANK_W];
            ptr      <= ptr + ADDR_TOTAL'(1);
            if (beats == '0) state <= DRAIN;
            else             beats <= beats - LEN_W'(1);
          end
        end
        DRAIN: begin
          // Completion is reported once the last read's data has landed in the queue.
          if (inflight_nxt == '0) begin
            done      <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MPI_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wr_count <= '0;
      o_rd_count <= '0;
    end else begin
      if (wr_fire && (o_wr_count != '1)) o_wr_count <= o_wr_count + 32'd1;
      if (rd_fire && (o_rd_count != '1)) o_rd_count <= o_rd_count + 32'd1;
    end
  end
`endif

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_wdata_ready = wdata_ready;
  assign bus.o_rdata_valid = !q_empty;
  assign bus.o_rdata       = q_data;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_en          = en;
  assign bus.o_we          = we;
  assign bus.o_din         = din;
  assign bus.o_addr        = addr;
  assign bus.o_bank_sel    = bank_sel;
  assign o_dbg_state       = state;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: behavioural 1-cycle-latency memory, flat reference memory,
// expected-queue scoreboard for port beats and returned read data.
module tb_mem_port_initiator;
  import mem_port_pkg::*;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  mem_port_initiator_if #(.WIDTH(8), .ADDR_TOTAL(10), .NUM_BANK(4), .MAX_BURST(16)) bus ();
  mpi_state_t dbg_state;
`ifdef MPI_STATS_EN
  logic [31:0] wr_count;
  logic [31:0] rd_count;
`endif

  mem_port_initiator #(
    .WIDTH(8), .ADDR_TOTAL(10), .NUM_BANK(4), .MAX_BURST(16), .RDQ_DEPTH(4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef MPI_STATS_EN
    ,
    .o_wr_count  (wr_count),
    .o_rd_count  (rd_count)
`endif
  );

  // ---------------- behavioural memory ----------------
  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  logic [7:0] tb_mem [1024];
  bit         tb_written [1024];

  always @(posedge i_clk) begin
    if (bus.o_en) begin
      if (bus.o_we) begin
        tb_mem[{bus.o_bank_sel, bus.o_addr}]     <= bus.o_din;
        tb_written[{bus.o_bank_sel, bus.o_addr}] <= 1'b1;
      end else begin
        bus.i_dout <= tb_written[{bus.o_bank_sel, bus.o_addr}] ?
                      tb_mem[{bus.o_bank_sel, bus.o_addr}] :
                      init_val(int'({bus.o_bank_sel, bus.o_addr}));
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  ref_mem [1024];
  logic [19:0] exp_port_q[$];   // {last, we, flat addr, data}
  logic [7:0]  exp_rd_q[$];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int exp_done   = 0;
  int rd_en_cnt  = 0;
  int rdy_mode   = 1;           // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (bus.o_done) done_cnt++;
      if (bus.o_en) begin
        logic [19:0] e;
        if (!bus.o_we) rd_en_cnt++;
        check("port_beat_expected", 32'(exp_port_q.size() != 0), 32'd1);
        if (exp_port_q.size() != 0) begin
          e = exp_port_q.pop_front();
          check("port_we", 32'(bus.o_we), 32'(e[18]));
          check("port_bank_addr", 32'({bus.o_bank_sel, bus.o_addr}), 32'(e[17:8]));
          if (bus.o_we) check("port_din", 32'(bus.o_din), 32'(e[7:0]));
          check("done_with_last_write", 32'(bus.o_done), 32'(e[19]));
        end
      end
      if (bus.o_rdata_valid && bus.i_rdata_ready) begin
        check("rdata_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0) check("rdata", 32'(bus.o_rdata), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  // ---------------- read-ready driver ----------------
  initial begin
    bus.i_rdata_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       bus.i_rdata_ready = 1'b0;
        1:       bus.i_rdata_ready = 1'b1;
        default: bus.i_rdata_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic we, input logic [9:0] addr, input logic [3:0] len);
    int   g;
    logic acc;
    g   = 0;
    acc = 1'b0;
    @(posedge i_clk);
    #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_len   = len;
    while (!acc && g < 200) begin
      @(negedge i_clk);
      acc = bus.o_cmd_ready;
      @(posedge i_clk);
      #1;
      g++;
    end
    bus.i_cmd_valid = 1'b0;
    check("cmd_accepted", 32'(acc), 32'd1);
  endtask

  task automatic do_write(input logic [9:0] addr, input int len, input bit rnd, input logic [7:0] base);
    logic [7:0] d [16];
    for (int i = 0; i <= len; i++) begin
      logic [9:0] a;
      a    = addr + 10'(i);
      d[i] = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      exp_port_q.push_back({(i == len), 1'b1, a, d[i]});
      ref_mem[a] = d[i];
    end
    send_cmd(1'b1, addr, 4'(len));
    for (int i = 0; i <= len; i++) begin
      int   gap;
      int   g;
      logic acc;
      gap = rnd ? $urandom_range(0, 2) : 0;
      bus.i_wdata_valid = 1'b0;
      repeat (gap) begin
        @(posedge i_clk);
        #1;
      end
      bus.i_wdata_valid = 1'b1;
      bus.i_wdata       = d[i];
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 100) begin
        @(negedge i_clk);
        acc = bus.o_wdata_ready;
        @(posedge i_clk);
        #1;
        g++;
      end
      check("wbeat_accepted", 32'(acc), 32'd1);
    end
    bus.i_wdata_valid = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] addr, input int len);
    for (int i = 0; i <= len; i++) begin
      logic [9:0] a;
      a = addr + 10'(i);
      exp_port_q.push_back({1'b0, 1'b0, a, 8'h00});
      exp_rd_q.push_back(ref_mem[a]);
    end
    send_cmd(1'b0, addr, 4'(len));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    exp_done++;
    while (done_cnt < exp_done && g < 600) begin
      @(negedge i_clk);
      #1;
      g++;
    end
    check("done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_rd_q.size() != 0 || exp_port_q.size() != 0) && g < 300) begin
      @(negedge i_clk);
      #1;
      g++;
    end
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("port_queue_drained", 32'(exp_port_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int done_before;
    int g;
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_val(a);
    bus.i_cmd_valid   = 1'b1;
    bus.i_cmd_we      = 1'b0;
    bus.i_cmd_addr    = '0;
    bus.i_cmd_len     = '0;
    bus.i_wdata_valid = 1'b0;
    bus.i_wdata       = '0;
    i_rst_n           = 1'b0;

    // 1: reset held with a command pending
    repeat (3) begin
      @(negedge i_clk);
      check("rst_en", 32'(bus.o_en), 32'd0);
      check("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_rdata_valid", 32'(bus.o_rdata_valid), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_rst_n         = 1'b1;
    bus.i_cmd_valid = 1'b0;
    @(negedge i_clk);
    check("cmd_ready_before_release_edge", 32'(bus.o_cmd_ready), 32'd0);
    @(negedge i_clk);
    check("cmd_ready_after_release", 32'(bus.o_cmd_ready), 32'd1);
    check("state_idle", 32'(dbg_state), 32'(IDLE));

    // 2: write crossing bank 0 -> bank 1
    do_write(10'h0FD, 3, 1'b0, 8'h20);
    wait_done();

    // 3: read it back with ready held high
    rdy_mode = 1;
    do_read(10'h0FD, 3);
    wait_done();
    drain();

    // 4: eight reads with the consumer stalled; only the queue depth may issue
    rdy_mode = 0;
    repeat (2) @(posedge i_clk);
    base = rd_en_cnt;
    do_read(10'h0F8, 7);
    repeat (30) @(negedge i_clk);
    check("stalled_read_issues", 32'(rd_en_cnt - base), 32'd4);
    check("stalled_rdata_valid", 32'(bus.o_rdata_valid), 32'd1);
    rdy_mode = 1;
    wait_done();
    drain();

    // 5: write wrapping the top of the address space
    do_write(10'h3FF, 1, 1'b0, 8'h5A);
    wait_done();
    do_read(10'h3FF, 1);
    wait_done();
    drain();

    // 6: reset while the second read beat is on the port
    base = rd_en_cnt;
    do_read(10'h120, 7);
    g = 0;
    while ((rd_en_cnt - base) < 2 && g < 100) begin
      @(negedge i_clk);
      #1;
      g++;
    end
    check("reached_read_beat2", 32'(rd_en_cnt - base), 32'd2);
    i_rst_n = 1'b0;
    exp_port_q.delete();
    exp_rd_q.delete();
    done_before = done_cnt;
    @(negedge i_clk);
    check("midburst_rst_en", 32'(bus.o_en), 32'd0);
    check("midburst_rst_rdata_valid", 32'(bus.o_rdata_valid), 32'd0);
    check("midburst_rst_busy", 32'(bus.o_busy), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(done_before));
    do_write(10'h120, 2, 1'b1, 8'h00);
    wait_done();
    do_read(10'h11F, 4);
    wait_done();
    drain();

    // randomized commands
    for (int n = 0; n < 14; n++) begin
      logic [9:0] a;
      int         len;
      a        = 10'($urandom_range(0, 1023));
      len      = $urandom_range(0, 15);
      rdy_mode = $urandom_range(1, 2);
      if ($urandom_range(0, 1) == 1) do_write(a, len, 1'b1, 8'h00);
      else                           do_read(a, len);
      wait_done();
    end
    rdy_mode = 1;
    drain();
    repeat (5) @(negedge i_clk);
    check("final_done_count", 32'(done_cnt), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
